// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path.
//   state_t         : controller state encoding
//   SZ_*            : RAM size codes (identical to RISC-V load/store funct3)
//   ERR_*           : response error codes
//   size_illegal()  : funct3 values that name no supported access size
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RESP   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_MISAL = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_SIZE  = 2'b11;

    // Size field 11 does not exist; 110 would be an unsigned word, which
    // is meaningless on a 32-bit datapath.
    function automatic logic size_illegal(input logic [2:0] funct3);
        return (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
    endfunction

endpackage

// File: rtl/mem_req_check.sv
// Combinational legality check for a memory request.
//   addr   in  32  byte address
//   funct3 in  3   size code (bit2 unsigned, [1:0] byte/half/word)
//   err    out 2   ERR_OK / ERR_MISAL / ERR_RANGE / ERR_SIZE
// Priority: illegal size, then out of range, then misalignment.
module mem_req_check
    import mem_pkg::*;
#(
    parameter int ADDR_BITS = 7
) (
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    output logic [1:0]  err
);

    always_comb begin
        err = ERR_OK;
        if (size_illegal(funct3)) begin
            err = ERR_SIZE;
        end else if ((addr >> ADDR_BITS) != 32'd0) begin
            err = ERR_RANGE;
        end else if (((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00))) begin
            err = ERR_MISAL;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the byte-addressed data-RAM interface.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : request handshake from the MEM stage (ready only in IDLE)
//   req_we/addr/wdata/funct3 : load/store request fields
//   resp_valid          : one-cycle response pulse
//   resp_rdata/resp_err : load result / error code, held until the next response
//   busy                : stall to the pipeline (state != IDLE)
//   mem_addr/din/we/u_b_h_w, mem_dout : RAM port (RAM writes on negedge,
//                         reads combinationally)
// A legal request spends LATENCY cycles in WAIT, one cycle in ACCESS, then
// one cycle in RESP. An illegal request goes straight to ERR.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int LATENCY   = 2,
    parameter int ADDR_BITS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_we,
    output logic [2:0]  mem_u_b_h_w,
    input  logic [31:0] mem_dout
);

    // Counter start value: WAIT exits the cycle after the counter reads 0.
    localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [1:0]  resp_err_q, resp_err_d;
    logic [1:0]  check_err;

    mem_req_check #(
        .ADDR_BITS (ADDR_BITS)
    ) u_check (
        .addr   (req_addr),
        .funct3 (req_funct3),
        .err    (check_err)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        funct3_d     = funct3_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    if (check_err != ERR_OK) begin
                        // Error response is loaded now so it is visible
                        // together with resp_valid in the ERR cycle.
                        state_d      = ST_ERR;
                        resp_err_d   = check_err;
                        resp_rdata_d = 32'd0;
                    end else if (LATENCY == 0) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                resp_rdata_d = we_q ? 32'd0 : mem_dout;
                resp_err_d   = ERR_OK;
                state_d      = ST_RESP;
            end
            ST_RESP:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            funct3_q     <= 3'd0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= ERR_OK;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // All handshake and RAM strobes decode registered state only, so a
    // changing request can never glitch mem_we, and reset drops it at once.
    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign resp_valid  = (state_q == ST_RESP) || (state_q == ST_ERR);
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mem_we      = (state_q == ST_ACCESS) && we_q;
    assign mem_addr    = addr_q;
    assign mem_din     = wdata_q;
    assign mem_u_b_h_w = funct3_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a LATENCY=2 instance driven by directed and
// random requests (scoreboard + reference model), and a LATENCY=0 instance
// for the back-to-back timing case. Both drive a small negedge-write RAM.
module tb_mem_access_ctrl;

    localparam int LAT       = 2;
    localparam int ADDR_BITS = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // LATENCY = 2 instance
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid_a, busy_a, mem_we_a;
    logic [31:0] resp_rdata_a, mem_addr_a, mem_din_a, mem_dout_a;
    logic [1:0]  resp_err_a;
    logic [2:0]  mem_sz_a;

    // LATENCY = 0 instance
    logic        req_valid_z, req_ready_z, req_we_z;
    logic [31:0] req_addr_z, req_wdata_z;
    logic [2:0]  req_funct3_z;
    logic        resp_valid_z, busy_z, mem_we_z;
    logic [31:0] resp_rdata_z, mem_addr_z, mem_din_z, mem_dout_z;
    logic [1:0]  resp_err_z;
    logic [2:0]  mem_sz_z;

    mem_access_ctrl #(.LATENCY(LAT), .ADDR_BITS(ADDR_BITS)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a), .resp_err(resp_err_a),
        .busy(busy_a), .mem_addr(mem_addr_a), .mem_din(mem_din_a), .mem_we(mem_we_a),
        .mem_u_b_h_w(mem_sz_a), .mem_dout(mem_dout_a)
    );

    mem_access_ctrl #(.LATENCY(0), .ADDR_BITS(ADDR_BITS)) u_dut_z (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_z), .req_ready(req_ready_z), .req_we(req_we_z),
        .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_funct3(req_funct3_z),
        .resp_valid(resp_valid_z), .resp_rdata(resp_rdata_z), .resp_err(resp_err_z),
        .busy(busy_z), .mem_addr(mem_addr_z), .mem_din(mem_din_z), .mem_we(mem_we_z),
        .mem_u_b_h_w(mem_sz_z), .mem_dout(mem_dout_z)
    );

    // ---------------- RAM models ----------------
    logic [7:0] ram_a [128];
    logic [7:0] ram_z [128];
    logic [6:0] ra_a, ra_z;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 73 + 29) ^ (i >> 2));
    endfunction

    function automatic logic [31:0] ram_fmt(input logic [2:0] sz,
                                            input logic [7:0] b0, b1, b2, b3);
        case (sz)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'd0, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'd0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    function automatic int size_bytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    always_comb begin
        ra_a = mem_addr_a[6:0];
        ra_z = mem_addr_z[6:0];
        mem_dout_a = ram_fmt(mem_sz_a, ram_a[ra_a], ram_a[7'(ra_a + 7'd1)],
                             ram_a[7'(ra_a + 7'd2)], ram_a[7'(ra_a + 7'd3)]);
        mem_dout_z = ram_fmt(mem_sz_z, ram_z[ra_z], ram_z[7'(ra_z + 7'd1)],
                             ram_z[7'(ra_z + 7'd2)], ram_z[7'(ra_z + 7'd3)]);
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            ram_a[i] = init_byte(i);
            ram_z[i] = 8'h00;
        end
        forever begin
            @(negedge clk);
            if (mem_we_a === 1'b1)
                for (int i = 0; i < size_bytes(mem_sz_a[1:0]); i++)
                    ram_a[7'(mem_addr_a[6:0] + 7'(i))] = mem_din_a[8*i +: 8];
            if (mem_we_z === 1'b1)
                for (int i = 0; i < size_bytes(mem_sz_z[1:0]); i++)
                    ram_z[7'(mem_addr_z[6:0] + 7'(i))] = mem_din_z[8*i +: 8];
        end
    end

    // ---------------- checking infrastructure ----------------
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          acc_cyc;
        int          lat;
        int          n_we;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] gold [128];

    // Reference model: what the memory system must answer, from the rules.
    function automatic logic [1:0] model_err(input logic [31:0] addr, input logic [2:0] f3);
        logic [31:0] nb;
        nb = 32'd1 << f3[1:0];
        if (f3 == 3'b011 || f3 == 3'b111 || f3 == 3'b110) return 2'b11;
        if (addr >= (32'd1 << ADDR_BITS))                  return 2'b10;
        if ((addr % nb) != 32'd0)                          return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_apply(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] f3, output exp_t e);
        int          nb;
        logic [31:0] val, mask;
        e.err   = model_err(addr, f3);
        e.rdata = 32'd0;
        e.n_we  = 0;
        e.lat   = (e.err != 2'b00) ? 1 : LAT + 2;
        if (e.err == 2'b00) begin
            nb = 1 << f3[1:0];
            if (we) begin
                for (int i = 0; i < nb; i++) gold[int'(addr) + i] = wdata[8*i +: 8];
                e.n_we = 1;
            end else begin
                val = 32'd0;
                for (int i = 0; i < nb; i++) val = val | (32'(gold[int'(addr) + i]) << (8 * i));
                if (!f3[2] && nb < 4 && val[8*nb-1]) begin
                    mask = (32'd1 << (8 * nb)) - 32'd1;
                    val  = val | ~mask;
                end
                e.rdata = val;
            end
        end
    endtask

    // Present one request; while the DUT is busy, optionally wiggle the bus
    // with a held-valid junk request that must be ignored.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input bit junk);
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 200) begin
            if (junk) begin
                req_valid  = 1'b1;
                req_we     = 1'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
                req_funct3 = 3'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            guard++;
            @(negedge clk);
        end
        check("req_ready_at_issue", 32'(req_ready), 32'd1);
        if (req_ready !== 1'b1) begin
            req_valid = 1'b0;
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        model_apply(we, addr, wdata, f3, e);
        e.acc_cyc = cyc;
        sb_q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((sb_q.size() != 0 || req_ready !== 1'b1) && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("drain_pending", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every response, checks hold otherwise.
    logic [31:0] last_rdata;
    logic [1:0]  last_err;
    int          we_cnt, we_cyc;

    initial begin
        exp_t e;
        last_rdata = 32'd0;
        last_err   = 2'd0;
        we_cnt     = 0;
        we_cyc     = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                last_rdata = 32'd0;
                last_err   = 2'd0;
                we_cnt     = 0;
            end else begin
                if (mem_we_a === 1'b1) begin
                    we_cnt++;
                    we_cyc = cyc;
                end
                if (resp_valid_a === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        check("resp_unexpected", 32'(resp_valid_a), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("resp_err", 32'(resp_err_a), 32'(e.err));
                        check("resp_rdata", resp_rdata_a, e.rdata);
                        check("resp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                        check("mem_we_cycles", 32'(we_cnt), 32'(e.n_we));
                        if (e.n_we == 1)
                            check("mem_we_cycle", 32'(we_cyc - e.acc_cyc), 32'(LAT + 1));
                        last_rdata = resp_rdata_a;
                        last_err   = resp_err_a;
                        we_cnt     = 0;
                    end
                end else begin
                    check("rdata_hold", resp_rdata_a, last_rdata);
                    check("err_hold", 32'(resp_err_a), 32'(last_err));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        int          r;

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0;
        req_valid_z = 1'b0; req_we_z = 1'b0; req_addr_z = 32'd0; req_wdata_z = 32'd0;
        req_funct3_z = 3'd0;
        for (int i = 0; i < 128; i++) gold[i] = init_byte(i);

        #1;
        check("rst_resp_valid", 32'(resp_valid_a), 32'd0);
        check("rst_resp_rdata", resp_rdata_a, 32'd0);
        check("rst_resp_err", 32'(resp_err_a), 32'd0);
        check("rst_mem_we", 32'(mem_we_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_z_req_ready", 32'(req_ready_z), 32'd1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Store word and read it back in every width.
        issue(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0);
        wait_idle();
        check("ram_byte_10", 32'(ram_a[16]), 32'hEF);
        check("ram_byte_11", 32'(ram_a[17]), 32'hBE);
        check("ram_byte_12", 32'(ram_a[18]), 32'hAD);
        check("ram_byte_13", 32'(ram_a[19]), 32'hDE);
        issue(1'b0, 32'h13, 32'd0, 3'b000, 1'b0);
        issue(1'b0, 32'h13, 32'd0, 3'b100, 1'b0);
        issue(1'b0, 32'h12, 32'd0, 3'b001, 1'b0);
        issue(1'b0, 32'h10, 32'd0, 3'b101, 1'b0);
        issue(1'b0, 32'h10, 32'd0, 3'b010, 1'b0);

        // Error paths.
        issue(1'b0, 32'h11, 32'd0, 3'b010, 1'b0);
        issue(1'b1, 32'h80, 32'h5555AAAA, 3'b001, 1'b0);
        issue(1'b0, 32'h00, 32'd0, 3'b011, 1'b0);
        issue(1'b0, 32'h00, 32'd0, 3'b110, 1'b0);
        issue(1'b1, 32'h1000_0000, 32'h1, 3'b000, 1'b0);
        issue(1'b1, 32'h81, 32'h1, 3'b010, 1'b0);

        // Requests held with changing fields while busy.
        issue(1'b1, 32'h30, 32'h11223344, 3'b010, 1'b1);
        issue(1'b0, 32'h30, 32'd0, 3'b010, 1'b1);
        issue(1'b0, 32'h31, 32'd0, 3'b100, 1'b1);
        wait_idle();

        // Reset during WAIT discards a store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h04;
        req_wdata = 32'hAAAAAAAA; req_funct3 = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("busy_in_wait", 32'(busy_a), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_busy", 32'(busy_a), 32'd0);
        check("rst_async_mem_we", 32'(mem_we_a), 32'd0);
        check("rst_async_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        check("ram_byte_04_kept", 32'(ram_a[4]), 32'(init_byte(4)));
        issue(1'b0, 32'h04, 32'd0, 3'b010, 1'b0);
        wait_idle();

        // Random traffic.
        for (int n = 0; n < 200; n++) begin
            r  = int'($urandom_range(0, 9));
            f3 = 3'($urandom);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'h80 + 32'($urandom_range(0, 15));
            else             a = 32'($urandom_range(0, 124));
            if (r < 7 && f3[1:0] != 2'b11) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'($urandom), a, $urandom, f3, 1'($urandom));
        end
        wait_idle();

        // LATENCY = 0: back-to-back store then load.
        @(negedge clk);
        check("z_ready_idle", 32'(req_ready_z), 32'd1);
        req_valid_z = 1'b1; req_we_z = 1'b1; req_addr_z = 32'h20;
        req_wdata_z = 32'h12345678; req_funct3_z = 3'b010;
        @(posedge clk);
        #1;
        req_we_z = 1'b0; req_wdata_z = 32'hCAFEF00D;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("z_resp_valid_c%0d", k), 32'(resp_valid_z),
                  32'((k == 2) || (k == 5)));
            if (k == 1) check("z_busy_c1", 32'(busy_z), 32'd1);
            if (k == 2) check("z_store_rdata", resp_rdata_z, 32'd0);
            if (k == 3) check("z_ready_c3", 32'(req_ready_z), 32'd1);
            if (k == 4) req_valid_z = 1'b0;
            if (k == 5) begin
                check("z_load_rdata", resp_rdata_z, 32'h12345678);
                check("z_load_err", 32'(resp_err_z), 32'd0);
            end
        end
        check("z_ram_byte_20", 32'(ram_z[32]), 32'h78);
        check("z_ram_byte_23", 32'(ram_z[35]), 32'h12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the byte-addressed data-RAM interface. The RAM writes on the negedge, reads combinationally, and takes the 3-bit unsigned/half/word size code.
- Accepts one load/store per handshake from the core MEM stage, checks alignment and range, and models memory latency with a wait counter.
- Drives the RAM for exactly one access cycle, then returns the result with a one-cycle response pulse. The pipeline stalls on busy.

Parameters:
- LATENCY, 2, wait cycles inserted before the access cycle (0..15).
- ADDR_BITS, 7, RAM byte-address width (128 bytes); address bits [31:ADDR_BITS] must be zero.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low-aligned.
- req_funct3  in  3  RISC-V funct3: bit2 = unsigned, [1:0] = 00 byte, 01 half, 10 word.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result, already sign/zero-extended by RAM; 0 for stores and errors.
- resp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal size.
- busy  out  1  state != IDLE; feeds the pipeline stall.
- mem_addr  out  32  RAM address.
- mem_din  out  32  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_u_b_h_w  out  3  RAM size code; equal to latched funct3.
- mem_dout  in  32  RAM read data.

Behaviour:
- Reset (async): state = IDLE, counter = 0, all latched request registers = 0.
  - Outputs after reset: resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_we = 0, busy = 0, req_ready = 1.
- States: IDLE, WAIT, ACCESS, RESP, ERR.
- IDLE: on req_valid, latch we/addr/wdata/funct3, then check the request in this order:
  - funct3[1:0] == 11, or funct3 == 110 → ERR with code 11.
  - address bits [31:ADDR_BITS] nonzero → ERR with code 10.
  - half with addr[0] set, or word with addr[1:0] != 0 → ERR with code 01.
  - otherwise → WAIT with counter = LATENCY-1, or → ACCESS directly if LATENCY == 0.
- WAIT: counter decrements each cycle; at 0 → ACCESS.
- ACCESS: mem_we = latched we for this whole cycle only.
  - mem_addr, mem_din and mem_u_b_h_w come from the latches (stable in all states).
  - At the closing posedge, capture mem_dout into resp_rdata (0 if store) → RESP.
- RESP: resp_valid = 1, resp_err = 00 → IDLE.
- ERR: resp_valid = 1, resp_err = latched code, resp_rdata = 0 → IDLE. The RAM is never written on this path.
- Timing, with the accept cycle as cycle 0:
  - Success: resp_valid in cycle LATENCY+2.
  - Error: resp_valid in cycle 1.
  - Next accept is possible in the cycle after resp_valid; throughput is one request per LATENCY+3 cycles.
- mem_we is decoded from registered state only. It is 0 in every state except ACCESS-with-store, and never glitches high on request changes.
- Requests presented while busy are ignored; req_ready = 0, and the requester holds them.
- Reset asserted mid-operation (WAIT or ACCESS) drops mem_we immediately and discards the request. A store reset before the ACCESS negedge does not reach RAM; no response is issued.
- Output stability: resp_rdata and resp_err hold their last values until the next response. resp_valid is a single-cycle pulse.

Decomposition:
- Shared package mem_pkg:
  - state encoding;
  - size constants SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010, SZ_BU = 3'b100, SZ_HU = 3'b101;
  - error codes ERR_OK, ERR_MISAL, ERR_RANGE, ERR_SIZE.
- One natural combinational sub-module, mem_req_check (addr, funct3 → err code), reused later by the fetch path.

Test Plan:
- Store word 0xDEADBEEF to 0x10, LATENCY = 2:
  - resp_valid at cycle 4, resp_err = 00;
  - mem_we high only in cycle 3;
  - bytes 0x10..0x13 = EF, BE, AD, DE.
- Loads after that store:
  - LB 0x13 → 0xFFFFFFDE;
  - LBU 0x13 → 0x000000DE;
  - LH 0x12 → 0xFFFFDEAD;
  - LHU 0x10 → 0x0000BEEF;
  - LW 0x10 → 0xDEADBEEF.
- LW at 0x11 → resp_err = 01 at cycle 1, mem_we never asserted. SH at 0x80 → resp_err = 10. funct3 = 011 → resp_err = 11.
- LATENCY = 0: back-to-back store 0x20 = 0x12345678 then LW 0x20 → resp_valid at cycles 2 and 5; second read = 0x12345678.
- Store 0x04 = 0xAAAAAAAA; assert rst during WAIT:
  - busy drops asynchronously, no resp_valid;
  - a later LW 0x04 returns the previous contents.
- req_valid held during busy with changing addr/wdata: latched request unaffected; second request accepted only in IDLE.
